// File: rtl/core_pkg.sv
// Shared widths, types and field offsets for the complex-unit reservation station.
package core_pkg;
    localparam int ENTRY_W = 114;
    localparam int ROB_W   = 4;
    localparam int DATA_W  = 32;

    localparam int MEMDATA_MSB  = 113;
    localparam int MEMDATA_LSB  = 82;
    localparam int ALUOP_MSB    = 81;
    localparam int ALUOP_LSB    = 76;
    localparam int MEMWRITE_BIT = 75;
    localparam int MEMREAD_BIT  = 74;
    localparam int MEMTOREG_BIT = 73;
    localparam int BRANCH_BIT   = 72;
    localparam int REGWRITE_BIT = 71;
    localparam int OP2_MSB      = 70;
    localparam int OP2_LSB      = 39;
    localparam int RDY2_BIT     = 38;
    localparam int OP1_MSB      = 37;
    localparam int OP1_LSB      = 6;
    localparam int RDY1_BIT     = 5;
    localparam int WRADDR_MSB   = 4;
    localparam int WRADDR_LSB   = 0;

    typedef logic [ENTRY_W-1:0] entry_t;
    typedef logic [ROB_W-1:0]   rob_t;
    typedef logic [DATA_W-1:0]  data_t;

    // An empty slot must never look ready to the issue logic.
    function automatic entry_t mask_empty(input entry_t e, input logic busy);
        entry_t r;
        r = e;
        if (!busy) begin
            r[RDY1_BIT] = 1'b0;
            r[RDY2_BIT] = 1'b0;
        end
        return r;
    endfunction
endpackage

// File: rtl/rs_complex_if.sv
// Dispatch, writeback-broadcast and issue signals between the pipeline and the station.
interface rs_complex_if;
    import core_pkg::*;

    // Handshake: a dispatch is accepted on a clk edge where dispatch_valid=1 and
    // rs_full=0; rs_full acts as the inverted ready and comes from registered state.
    logic   dispatch_valid;
    entry_t dispatch_inst;
    rob_t   dispatch_rob_num;
    logic   rs_full;
    logic   flush;

    logic   cdb0_valid;
    rob_t   cdb0_rob_num;
    data_t  cdb0_data;
    logic   cdb1_valid;
    rob_t   cdb1_rob_num;
    data_t  cdb1_data;

    entry_t rs_complex_0;
    entry_t rs_complex_1;
    rob_t   rs_complex_0_entry_num;
    rob_t   rs_complex_1_entry_num;
    logic   selector;
    logic   complex_0_issue;
    logic   complex_1_issue;

    modport master (
        output dispatch_valid, dispatch_inst, dispatch_rob_num, flush,
        output cdb0_valid, cdb0_rob_num, cdb0_data,
        output cdb1_valid, cdb1_rob_num, cdb1_data,
        output complex_0_issue, complex_1_issue,
        input  rs_full, rs_complex_0, rs_complex_1,
        input  rs_complex_0_entry_num, rs_complex_1_entry_num, selector
    );

    modport slave (
        input  dispatch_valid, dispatch_inst, dispatch_rob_num, flush,
        input  cdb0_valid, cdb0_rob_num, cdb0_data,
        input  cdb1_valid, cdb1_rob_num, cdb1_data,
        input  complex_0_issue, complex_1_issue,
        output rs_full, rs_complex_0, rs_complex_1,
        output rs_complex_0_entry_num, rs_complex_1_entry_num, selector
    );
endinterface

// File: rtl/rs_operand_capture.sv
// Resolves one source operand against both writeback buses; cdb0 wins a double match.
module rs_operand_capture
    import core_pkg::*;
(
    input  data_t op,
    input  logic  rdy,
    input  logic  cdb0_valid,
    input  rob_t  cdb0_rob_num,
    input  data_t cdb0_data,
    input  logic  cdb1_valid,
    input  rob_t  cdb1_rob_num,
    input  data_t cdb1_data,
    output data_t op_next,
    output logic  rdy_next
);
    always_comb begin
        op_next  = op;
        rdy_next = rdy;
        if (!rdy) begin
            if (cdb0_valid && (cdb0_rob_num == op[ROB_W-1:0])) begin
                op_next  = cdb0_data;
                rdy_next = 1'b1;
            end else if (cdb1_valid && (cdb1_rob_num == op[ROB_W-1:0])) begin
                op_next  = cdb1_data;
                rdy_next = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rs_complex.sv
// Two-entry reservation station for the complex execution unit.
module rs_complex
    import core_pkg::*;
(
    input logic         clk,
    input logic         rst,
    rs_complex_if.slave bus
);
    logic [1:0] busy;
    entry_t     entry_q [2];
    rob_t       tag_q   [2];
    logic       sel_q;

    data_t  disp_op1, disp_op2;
    logic   disp_rdy1, disp_rdy2;
    entry_t disp_entry;

    data_t  wake_op1  [2];
    data_t  wake_op2  [2];
    logic   wake_rdy1 [2];
    logic   wake_rdy2 [2];
    entry_t wake_entry [2];

    logic       full;
    logic       alloc_en;
    logic       alloc_idx;
    logic [1:0] issue;

    rs_operand_capture cap_disp1 (
        .op(bus.dispatch_inst[OP1_MSB:OP1_LSB]), .rdy(bus.dispatch_inst[RDY1_BIT]),
        .cdb0_valid(bus.cdb0_valid), .cdb0_rob_num(bus.cdb0_rob_num), .cdb0_data(bus.cdb0_data),
        .cdb1_valid(bus.cdb1_valid), .cdb1_rob_num(bus.cdb1_rob_num), .cdb1_data(bus.cdb1_data),
        .op_next(disp_op1), .rdy_next(disp_rdy1)
    );

    rs_operand_capture cap_disp2 (
        .op(bus.dispatch_inst[OP2_MSB:OP2_LSB]), .rdy(bus.dispatch_inst[RDY2_BIT]),
        .cdb0_valid(bus.cdb0_valid), .cdb0_rob_num(bus.cdb0_rob_num), .cdb0_data(bus.cdb0_data),
        .cdb1_valid(bus.cdb1_valid), .cdb1_rob_num(bus.cdb1_rob_num), .cdb1_data(bus.cdb1_data),
        .op_next(disp_op2), .rdy_next(disp_rdy2)
    );

    for (genvar g = 0; g < 2; g++) begin : g_wake
        rs_operand_capture cap_op1 (
            .op(entry_q[g][OP1_MSB:OP1_LSB]), .rdy(entry_q[g][RDY1_BIT]),
            .cdb0_valid(bus.cdb0_valid), .cdb0_rob_num(bus.cdb0_rob_num), .cdb0_data(bus.cdb0_data),
            .cdb1_valid(bus.cdb1_valid), .cdb1_rob_num(bus.cdb1_rob_num), .cdb1_data(bus.cdb1_data),
            .op_next(wake_op1[g]), .rdy_next(wake_rdy1[g])
        );

        rs_operand_capture cap_op2 (
            .op(entry_q[g][OP2_MSB:OP2_LSB]), .rdy(entry_q[g][RDY2_BIT]),
            .cdb0_valid(bus.cdb0_valid), .cdb0_rob_num(bus.cdb0_rob_num), .cdb0_data(bus.cdb0_data),
            .cdb1_valid(bus.cdb1_valid), .cdb1_rob_num(bus.cdb1_rob_num), .cdb1_data(bus.cdb1_data),
            .op_next(wake_op2[g]), .rdy_next(wake_rdy2[g])
        );

        always_comb begin
            wake_entry[g]                  = entry_q[g];
            wake_entry[g][OP1_MSB:OP1_LSB] = wake_op1[g];
            wake_entry[g][RDY1_BIT]        = wake_rdy1[g];
            wake_entry[g][OP2_MSB:OP2_LSB] = wake_op2[g];
            wake_entry[g][RDY2_BIT]        = wake_rdy2[g];
        end
    end

    always_comb begin
        disp_entry                  = bus.dispatch_inst;
        disp_entry[OP1_MSB:OP1_LSB] = disp_op1;
        disp_entry[RDY1_BIT]        = disp_rdy1;
        disp_entry[OP2_MSB:OP2_LSB] = disp_op2;
        disp_entry[RDY2_BIT]        = disp_rdy2;
    end

    // Allocation looks only at registered busy, so a slot freed this cycle refills next cycle.
    always_comb begin
        full      = busy[0] & busy[1];
        alloc_en  = bus.dispatch_valid & ~full;
        alloc_idx = busy[0];
        issue     = {bus.complex_1_issue, bus.complex_0_issue};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            sel_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                entry_q[k] <= '0;
                tag_q[k]   <= '0;
            end
        end else if (bus.flush) begin
            busy <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (busy[k]) entry_q[k] <= wake_entry[k];
                if (issue[k]) busy[k] <= 1'b0;
            end
            // Allocation targets a slot that was free, so it never collides with issue or wakeup.
            if (alloc_en) begin
                busy[alloc_idx]    <= 1'b1;
                entry_q[alloc_idx] <= disp_entry;
                tag_q[alloc_idx]   <= bus.dispatch_rob_num;
                sel_q              <= alloc_idx;
            end
        end
    end

    assign bus.rs_full                = full;
    assign bus.rs_complex_0           = mask_empty(entry_q[0], busy[0]);
    assign bus.rs_complex_1           = mask_empty(entry_q[1], busy[1]);
    assign bus.rs_complex_0_entry_num = tag_q[0];
    assign bus.rs_complex_1_entry_num = tag_q[1];
    assign bus.selector               = sel_q;
endmodule

// File: tb/tb_rs_complex.sv
// Directed bench for rs_complex: per-cycle reference model plus hand-computed checkpoints.
module tb_rs_complex;
    import core_pkg::*;

    logic clk;
    logic rst;
    rs_complex_if bus ();

    rs_complex dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    task automatic check(input string name, input entry_t act, input entry_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic   m_busy [2];
    entry_t m_ent  [2];
    rob_t   m_tag  [2];
    logic   m_sel;

    // An operand picks up the value of the first valid bus carrying its tag, cdb0 first.
    function automatic logic [DATA_W:0] resolve(input data_t op, input logic rdy);
        if (rdy) return {1'b1, op};
        if (bus.cdb0_valid && bus.cdb0_rob_num == op[3:0]) return {1'b1, bus.cdb0_data};
        if (bus.cdb1_valid && bus.cdb1_rob_num == op[3:0]) return {1'b1, bus.cdb1_data};
        return {1'b0, op};
    endfunction

    function automatic entry_t resolve_entry(input entry_t e);
        entry_t r;
        logic [DATA_W:0] a, b;
        r = e;
        a = resolve(e[OP1_MSB:OP1_LSB], e[RDY1_BIT]);
        b = resolve(e[OP2_MSB:OP2_LSB], e[RDY2_BIT]);
        {r[RDY1_BIT], r[OP1_MSB:OP1_LSB]} = a;
        {r[RDY2_BIT], r[OP2_MSB:OP2_LSB]} = b;
        return r;
    endfunction

    function automatic entry_t shown(input int k);
        entry_t r;
        r = m_ent[k];
        if (!m_busy[k]) begin
            r[RDY1_BIT] = 1'b0;
            r[RDY2_BIT] = 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic was_busy [2];
        bit   was_full;
        int   slot;
        was_busy[0] = m_busy[0];
        was_busy[1] = m_busy[1];
        was_full    = m_busy[0] && m_busy[1];
        if (rst) begin
            m_sel = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b0; m_ent[k] = '0; m_tag[k] = '0;
            end
        end else if (bus.flush) begin
            m_busy[0] = 1'b0;
            m_busy[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (was_busy[k]) m_ent[k] = resolve_entry(m_ent[k]);
            if (bus.complex_0_issue) m_busy[0] = 1'b0;
            if (bus.complex_1_issue) m_busy[1] = 1'b0;
            if (bus.dispatch_valid && !was_full) begin
                slot = was_busy[0] ? 1 : 0;
                m_ent[slot]  = resolve_entry(bus.dispatch_inst);
                m_tag[slot]  = bus.dispatch_rob_num;
                m_busy[slot] = 1'b1;
                m_sel        = slot[0];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("model_rs_full", ENTRY_W'(bus.rs_full), ENTRY_W'(m_busy[0] && m_busy[1]));
                check("model_selector", ENTRY_W'(bus.selector), ENTRY_W'(m_sel));
                check("model_entry0", bus.rs_complex_0, shown(0));
                check("model_entry1", bus.rs_complex_1, shown(1));
                check("model_tag0", ENTRY_W'(bus.rs_complex_0_entry_num), ENTRY_W'(m_tag[0]));
                check("model_tag1", ENTRY_W'(bus.rs_complex_1_entry_num), ENTRY_W'(m_tag[1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.dispatch_valid   = 1'b0;
        bus.dispatch_inst    = '0;
        bus.dispatch_rob_num = '0;
        bus.flush            = 1'b0;
        bus.cdb0_valid       = 1'b0;
        bus.cdb0_rob_num     = '0;
        bus.cdb0_data        = '0;
        bus.cdb1_valid       = 1'b0;
        bus.cdb1_rob_num     = '0;
        bus.cdb1_data        = '0;
        bus.complex_0_issue  = 1'b0;
        bus.complex_1_issue  = 1'b0;
    endtask

    // Inputs set before tick() apply at the next rising edge, then are cleared.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic entry_t mk_inst(input data_t op1, input logic r1,
                                       input data_t op2, input logic r2, input logic [4:0] wr);
        return {32'h1234_5678, 6'h2A, 5'b10101, op2, r2, op1, r1, wr};
    endfunction

    task automatic dispatch(input entry_t inst, input rob_t rob);
        bus.dispatch_valid   = 1'b1;
        bus.dispatch_inst    = inst;
        bus.dispatch_rob_num = rob;
    endtask

    task automatic cdb(input int n, input rob_t rob, input data_t d);
        if (n == 0) begin
            bus.cdb0_valid = 1'b1; bus.cdb0_rob_num = rob; bus.cdb0_data = d;
        end else begin
            bus.cdb1_valid = 1'b1; bus.cdb1_rob_num = rob; bus.cdb1_data = d;
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        model_on = 1'b1;
        tick();
        settle();
        check("reset_full", ENTRY_W'(bus.rs_full), '0);
        check("reset_entry0", bus.rs_complex_0, '0);
        check("reset_entry1", bus.rs_complex_1, '0);
        check("reset_selector", ENTRY_W'(bus.selector), '0);
        rst = 1'b0;

        // Both operands ready at dispatch.
        dispatch(mk_inst(32'd5, 1'b1, 32'd7, 1'b1, 5'd3), 4'd3);
        tick(); settle();
        check("t1_op1", ENTRY_W'(bus.rs_complex_0[37:6]), ENTRY_W'(5));
        check("t1_op2", ENTRY_W'(bus.rs_complex_0[70:39]), ENTRY_W'(7));
        check("t1_rdy", ENTRY_W'({bus.rs_complex_0[38], bus.rs_complex_0[5]}), ENTRY_W'(2'b11));
        check("t1_tag", ENTRY_W'(bus.rs_complex_0_entry_num), ENTRY_W'(3));
        check("t1_sel", ENTRY_W'(bus.selector), '0);
        check("t1_full", ENTRY_W'(bus.rs_full), '0);

        // Operand 1 waits on tag 9, woken by cdb1 two cycles after dispatch.
        dispatch(mk_inst(32'd9, 1'b0, 32'h55, 1'b1, 5'd4), 4'd4);
        tick(); settle();
        check("t2_full", ENTRY_W'(bus.rs_full), ENTRY_W'(1));
        check("t2_sel", ENTRY_W'(bus.selector), ENTRY_W'(1));
        tick(); settle();
        check("t2_wait_rdy1", ENTRY_W'(bus.rs_complex_1[5]), '0);
        check("t2_wait_op1", ENTRY_W'(bus.rs_complex_1[37:6]), ENTRY_W'(9));
        cdb(1, 4'd9, 32'hDEAD_BEEF);
        tick(); settle();
        check("t2_woken_op1", ENTRY_W'(bus.rs_complex_1[37:6]), ENTRY_W'(32'hDEAD_BEEF));
        check("t2_woken_rdy1", ENTRY_W'(bus.rs_complex_1[5]), ENTRY_W'(1));
        check("t2_op2_kept", ENTRY_W'(bus.rs_complex_1[70:39]), ENTRY_W'(32'h55));

        // Double issue frees both; next dispatch lands in entry 0.
        bus.complex_0_issue = 1'b1; bus.complex_1_issue = 1'b1;
        tick(); settle();
        check("t5_full", ENTRY_W'(bus.rs_full), '0);
        check("t5_rdy0", ENTRY_W'({bus.rs_complex_0[38], bus.rs_complex_0[5]}), '0);
        check("t5_rdy1", ENTRY_W'({bus.rs_complex_1[38], bus.rs_complex_1[5]}), '0);
        dispatch(mk_inst(32'd1, 1'b1, 32'd2, 1'b1, 5'd1), 4'd1);
        tick(); settle();
        check("t5_tag0", ENTRY_W'(bus.rs_complex_0_entry_num), ENTRY_W'(1));
        check("t5_sel", ENTRY_W'(bus.selector), '0);

        // Fill, ignored third dispatch, single issue.
        dispatch(mk_inst(32'd3, 1'b1, 32'd4, 1'b1, 5'd2), 4'd2);
        tick(); settle();
        check("t3_full", ENTRY_W'(bus.rs_full), ENTRY_W'(1));
        check("t3_sel", ENTRY_W'(bus.selector), ENTRY_W'(1));
        dispatch(mk_inst(32'd8, 1'b1, 32'd8, 1'b1, 5'd7), 4'd7);
        tick(); settle();
        check("t3_ignored_tag0", ENTRY_W'(bus.rs_complex_0_entry_num), ENTRY_W'(1));
        check("t3_ignored_tag1", ENTRY_W'(bus.rs_complex_1_entry_num), ENTRY_W'(2));
        check("t3_ignored_sel", ENTRY_W'(bus.selector), ENTRY_W'(1));
        bus.complex_0_issue = 1'b1;
        tick(); settle();
        check("t3_issue_full", ENTRY_W'(bus.rs_full), '0);
        check("t3_issue_rdy0", ENTRY_W'({bus.rs_complex_0[38], bus.rs_complex_0[5]}), '0);

        // Free-then-refill: dispatch in the issue cycle stalls one cycle.
        dispatch(mk_inst(32'd6, 1'b1, 32'd6, 1'b1, 5'd5), 4'd5);
        tick(); settle();
        check("refill_tag0", ENTRY_W'(bus.rs_complex_0_entry_num), ENTRY_W'(5));
        bus.complex_1_issue = 1'b1;
        dispatch(mk_inst(32'd7, 1'b1, 32'd7, 1'b1, 5'd8), 4'd8);
        tick(); settle();
        check("refill_stall_tag1", ENTRY_W'(bus.rs_complex_1_entry_num), ENTRY_W'(2));
        check("refill_stall_sel", ENTRY_W'(bus.selector), '0);
        dispatch(mk_inst(32'd7, 1'b1, 32'd7, 1'b1, 5'd8), 4'd8);
        tick(); settle();
        check("refill_tag1", ENTRY_W'(bus.rs_complex_1_entry_num), ENTRY_W'(8));
        check("refill_sel", ENTRY_W'(bus.selector), ENTRY_W'(1));

        // Dispatch-time capture with both buses matching: cdb0 wins.
        bus.complex_0_issue = 1'b1; bus.complex_1_issue = 1'b1;
        tick();
        dispatch(mk_inst(32'd1, 1'b1, 32'd6, 1'b0, 5'd9), 4'hB);
        cdb(0, 4'd6, 32'h11);
        cdb(1, 4'd6, 32'h22);
        tick(); settle();
        check("prio_op2", ENTRY_W'(bus.rs_complex_0[70:39]), ENTRY_W'(32'h11));
        check("prio_rdy2", ENTRY_W'(bus.rs_complex_0[38]), ENTRY_W'(1));

        // Flush with both busy, dispatch and a matching cdb.
        dispatch(mk_inst(32'hA, 1'b0, 32'd3, 1'b1, 5'd10), 4'hC);
        tick();
        bus.flush = 1'b1;
        dispatch(mk_inst(32'd2, 1'b1, 32'd2, 1'b1, 5'd11), 4'hD);
        cdb(0, 4'hA, 32'h99);
        tick(); settle();
        check("flush_full", ENTRY_W'(bus.rs_full), '0);
        check("flush_rdy0", ENTRY_W'({bus.rs_complex_0[38], bus.rs_complex_0[5]}), '0);
        check("flush_rdy1", ENTRY_W'({bus.rs_complex_1[38], bus.rs_complex_1[5]}), '0);
        check("flush_sel", ENTRY_W'(bus.selector), ENTRY_W'(1));

        // Flush overriding a dispatch that had a free slot.
        dispatch(mk_inst(32'd4, 1'b1, 32'd4, 1'b1, 5'd12), 4'hD);
        tick();
        bus.flush = 1'b1;
        dispatch(mk_inst(32'd5, 1'b1, 32'd5, 1'b1, 5'd13), 4'hE);
        tick(); settle();
        check("flush2_full", ENTRY_W'(bus.rs_full), '0);
        check("flush2_tag1", ENTRY_W'(bus.rs_complex_1_entry_num), ENTRY_W'(4'hC));
        check("flush2_sel", ENTRY_W'(bus.selector), '0);

        // Reset in the middle of a wakeup.
        dispatch(mk_inst(32'd3, 1'b0, 32'd1, 1'b1, 5'd14), 4'hF);
        tick();
        rst = 1'b1;
        cdb(0, 4'd3, 32'h77);
        tick(); settle();
        check("rst_entry0", bus.rs_complex_0, '0);
        check("rst_entry1", bus.rs_complex_1, '0);
        check("rst_tags", ENTRY_W'({bus.rs_complex_0_entry_num, bus.rs_complex_1_entry_num}), '0);
        check("rst_sel_full", ENTRY_W'({bus.selector, bus.rs_full}), '0);
        rst = 1'b0;
        dispatch(mk_inst(32'd9, 1'b1, 32'd9, 1'b1, 5'd15), 4'd2);
        tick(); settle();
        check("post_rst_tag0", ENTRY_W'(bus.rs_complex_0_entry_num), ENTRY_W'(2));

        tick(); tick(); settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
